// File: rtl/rv32i_clint_pkg.sv
// rtl/rv32i_clint_pkg.sv - register map and field positions of the CLINT MMIO window
package rv32i_clint_pkg;

    // Number of low address bits covered by the 32-byte window.
    localparam int CLINT_WIN_BITS = 5;

    // Word index within the window (addr[4:2]).
    localparam logic [2:0] CLINT_MSIP        = 3'd0;
    localparam logic [2:0] CLINT_MTIMECMP_LO = 3'd1;
    localparam logic [2:0] CLINT_MTIMECMP_HI = 3'd2;
    localparam logic [2:0] CLINT_MTIME_LO    = 3'd3;
    localparam logic [2:0] CLINT_MTIME_HI    = 3'd4;
    localparam logic [2:0] CLINT_EICTRL      = 3'd5;
    localparam logic [2:0] CLINT_EIPEND      = 3'd6;
    localparam logic [2:0] CLINT_RSVD        = 3'd7;

    // EICTRL field positions.
    localparam int EICTRL_EN_BIT   = 0;
    localparam int EICTRL_EDGE_BIT = 1;

endpackage

// File: rtl/rv32i_irq_sync.sv
// rtl/rv32i_irq_sync.sv - multi-flop synchroniser with rising-edge detect for one IRQ line
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   irq_raw   in   asynchronous interrupt line
//   irq_s     out  synchronised level (last flop of the chain)
//   irq_rise  out  irq_s & ~(irq_s delayed one cycle), combinational from flops
module rv32i_irq_sync #(
    parameter int SYNC_STAGES = 2    // must be >= 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_raw,
    output logic irq_s,
    output logic irq_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   irq_d_q;
    logic                   irq_d_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], irq_raw};
        irq_d_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            irq_d_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            irq_d_q <= irq_d_d;
        end
    end

    assign irq_s    = sync_q[SYNC_STAGES-1];
    assign irq_rise = sync_q[SYNC_STAGES-1] & ~irq_d_q;

endmodule

// File: rtl/rv32i_clint_mmio.sv
// rtl/rv32i_clint_mmio.sv - memory-mapped software/external interrupt and timer-write front end
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   addr, wdata, wr_mask, wr_en core data-bus store interface (wdata already lane-aligned)
//   rdata, sel_q                registered read data / window hit of the previous cycle's addr
//   ext_irq_raw                 asynchronous external interrupt line
//   software_interrupt          MSIP[0]
//   external_interrupt          enable & (edge_mode ? pending : synchronised level), registered
//   mtime_wr, mtime_din         one-cycle commit pulse and {HI, staged LO} for mtime
//   mtimecmp_wr, mtimecmp_din   one-cycle commit pulse and {HI, staged LO} for mtimecmp
module rv32i_clint_mmio
    import rv32i_clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wr_mask,
    input  logic        wr_en,
    output logic [31:0] rdata,
    output logic        sel_q,
    input  logic        ext_irq_raw,
    output logic        software_interrupt,
    output logic        external_interrupt,
    output logic        mtime_wr,
    output logic [63:0] mtime_din,
    output logic        mtimecmp_wr,
    output logic [63:0] mtimecmp_din
);

    // Replace only the byte lanes whose enable is set.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  mask
    );
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = mask[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    // Synchroniser outputs
    logic irq_s;
    logic irq_rise;

    rv32i_irq_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ext_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq_raw  (ext_irq_raw),
        .irq_s    (irq_s),
        .irq_rise (irq_rise)
    );

    // Register state
    logic        msip_q,        msip_d;
    logic [31:0] mtimecmp_lo_q, mtimecmp_lo_d;
    logic [31:0] mtimecmp_hi_q, mtimecmp_hi_d;
    logic [31:0] mtime_lo_q,    mtime_lo_d;
    logic [31:0] mtime_hi_q,    mtime_hi_d;
    logic [1:0]  eictrl_q,      eictrl_d;
    logic        eipend_q,      eipend_d;

    // Output flops
    logic [31:0] rdata_q,        rdata_d;
    logic        sel_d;
    logic        mtime_wr_q,     mtime_wr_d;
    logic [63:0] mtime_din_q,    mtime_din_d;
    logic        mtimecmp_wr_q,  mtimecmp_wr_d;
    logic [63:0] mtimecmp_din_q, mtimecmp_din_d;
    logic        ext_int_q,      ext_int_d;

    // Decode
    logic        hit;
    logic        wsel;
    logic [2:0]  word;
    logic        eipend_clr;
    logic [31:0] merged;

    // Byte offset within a word is irrelevant to this block.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

    always_comb begin
        hit    = (addr[31:CLINT_WIN_BITS] == BASE_ADDR[31:CLINT_WIN_BITS]);
        wsel   = hit & wr_en;
        word   = addr[4:2];
        merged = 32'h0;

        msip_d         = msip_q;
        mtimecmp_lo_d  = mtimecmp_lo_q;
        mtimecmp_hi_d  = mtimecmp_hi_q;
        mtime_lo_d     = mtime_lo_q;
        mtime_hi_d     = mtime_hi_q;
        eictrl_d       = eictrl_q;
        eipend_clr     = 1'b0;
        mtime_wr_d     = 1'b0;
        mtime_din_d    = mtime_din_q;
        mtimecmp_wr_d  = 1'b0;
        mtimecmp_din_d = mtimecmp_din_q;

        if (wsel) begin
            case (word)
                CLINT_MSIP: begin
                    if (wr_mask[0]) msip_d = wdata[0];
                end
                CLINT_MTIMECMP_LO: begin
                    mtimecmp_lo_d = merge_lanes(mtimecmp_lo_q, wdata, wr_mask);
                end
                CLINT_MTIMECMP_HI: begin
                    // Any HI store commits, even with an empty mask.
                    merged         = merge_lanes(mtimecmp_hi_q, wdata, wr_mask);
                    mtimecmp_hi_d  = merged;
                    mtimecmp_wr_d  = 1'b1;
                    mtimecmp_din_d = {merged, mtimecmp_lo_q};
                end
                CLINT_MTIME_LO: begin
                    mtime_lo_d = merge_lanes(mtime_lo_q, wdata, wr_mask);
                end
                CLINT_MTIME_HI: begin
                    merged      = merge_lanes(mtime_hi_q, wdata, wr_mask);
                    mtime_hi_d  = merged;
                    mtime_wr_d  = 1'b1;
                    mtime_din_d = {merged, mtime_lo_q};
                end
                CLINT_EICTRL: begin
                    if (wr_mask[0]) eictrl_d = wdata[1:0];
                end
                CLINT_EIPEND: begin
                    eipend_clr = wr_mask[0] & wdata[0];
                end
                default: begin
                end
            endcase
        end

        // A new rising edge wins over a simultaneous write-one-to-clear.
        eipend_d = irq_rise | (eipend_q & ~eipend_clr);

        ext_int_d = eictrl_q[EICTRL_EN_BIT] &
                    (eictrl_q[EICTRL_EDGE_BIT] ? eipend_q : irq_s);

        // Read path uses current register values, so a same-cycle write is not visible yet.
        rdata_d = 32'h0;
        sel_d   = hit;
        if (hit) begin
            case (word)
                CLINT_MSIP:        rdata_d = {31'h0, msip_q};
                CLINT_MTIMECMP_LO: rdata_d = mtimecmp_lo_q;
                CLINT_MTIMECMP_HI: rdata_d = mtimecmp_hi_q;
                CLINT_MTIME_LO:    rdata_d = mtime_lo_q;
                CLINT_MTIME_HI:    rdata_d = mtime_hi_q;
                CLINT_EICTRL:      rdata_d = {30'h0, eictrl_q};
                CLINT_EIPEND:      rdata_d = {31'h0, eipend_q};
                CLINT_RSVD:        rdata_d = 32'h0;
                default:           rdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msip_q         <= 1'b0;
            mtimecmp_lo_q  <= 32'h0;
            mtimecmp_hi_q  <= 32'h0;
            mtime_lo_q     <= 32'h0;
            mtime_hi_q     <= 32'h0;
            eictrl_q       <= 2'b00;
            eipend_q       <= 1'b0;
            rdata_q        <= 32'h0;
            sel_q          <= 1'b0;
            mtime_wr_q     <= 1'b0;
            mtime_din_q    <= 64'h0;
            mtimecmp_wr_q  <= 1'b0;
            mtimecmp_din_q <= 64'h0;
            ext_int_q      <= 1'b0;
        end else begin
            msip_q         <= msip_d;
            mtimecmp_lo_q  <= mtimecmp_lo_d;
            mtimecmp_hi_q  <= mtimecmp_hi_d;
            mtime_lo_q     <= mtime_lo_d;
            mtime_hi_q     <= mtime_hi_d;
            eictrl_q       <= eictrl_d;
            eipend_q       <= eipend_d;
            rdata_q        <= rdata_d;
            sel_q          <= sel_d;
            mtime_wr_q     <= mtime_wr_d;
            mtime_din_q    <= mtime_din_d;
            mtimecmp_wr_q  <= mtimecmp_wr_d;
            mtimecmp_din_q <= mtimecmp_din_d;
            ext_int_q      <= ext_int_d;
        end
    end

    assign rdata              = rdata_q;
    assign software_interrupt = msip_q;
    assign external_interrupt = ext_int_q;
    assign mtime_wr           = mtime_wr_q;
    assign mtime_din          = mtime_din_q;
    assign mtimecmp_wr        = mtimecmp_wr_q;
    assign mtimecmp_din       = mtimecmp_din_q;

endmodule
